// File: rtl/gate_tt_pkg.sv
// Shared types and reference truth tables for the gate truth-table scanner.
// Tables are indexed by {a,b}, so bit 3 holds the output for a=1, b=1.
package gate_tt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_VECTORS = 4;

  localparam logic [3:0] OR_TT   = 4'b1110;
  localparam logic [3:0] AND_TT  = 4'b1000;
  localparam logic [3:0] XOR_TT  = 4'b0110;
  localparam logic [3:0] NAND_TT = 4'b0111;
  localparam logic [3:0] NOR_TT  = 4'b0001;
  localparam logic [3:0] XNOR_TT = 4'b1001;

endpackage

// File: rtl/gate_tt_settle_timer.sv
// Settle counter: clear has priority over enable. term flags the last held
// cycle, so it is already high on the edge that ends the settle window.
module gate_tt_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] count,
  output logic       term
);

  localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (!rst_n)    count <= '0;
    else if (clr)  count <= '0;
    else if (en)   count <= count + 4'd1;
  end

  assign term = (count == LAST);

endmodule

// File: rtl/gate_tt_scanner.sv
// Walks a 2-input gate through {a,b} = 00..11, samples o_in after settling
// and compares the captured truth table against the table latched at start.
module gate_tt_scanner
  import gate_tt_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] expected,
  output logic       a_out,
  output logic       b_out,
  input  logic       o_in,
  output logic       busy,
  output logic       done,
  output logic [3:0] tt,
  output logic       match
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_VECTORS - 1);

  state_t     state;
  logic [1:0] idx;
  logic [1:0] idx_nxt;
  logic [3:0] exp_q;
  logic       valid_q;
  logic [3:0] count;
  logic       term;

  // Counter runs only while inputs are held; any other state parks it at 0.
  gate_tt_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != DRIVE),
    .en    (state == DRIVE),
    .count (count),
    .term  (term)
  );

  assign idx_nxt = idx + 2'd1;
  assign match   = valid_q & (tt == exp_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      exp_q   <= '0;
      tt      <= '0;
      valid_q <= 1'b0;
      a_out   <= 1'b0;
      b_out   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= DRIVE;
            idx     <= '0;
            exp_q   <= expected;
            tt      <= '0;
            valid_q <= 1'b0;
            a_out   <= 1'b0;
            b_out   <= 1'b0;
            busy    <= 1'b1;
          end
        end
        DRIVE: begin
          if (term) state <= SAMPLE;
        end
        SAMPLE: begin
          tt[idx] <= o_in;
          if (idx == LAST_IDX) begin
            state   <= DONE;
            valid_q <= 1'b1;
            done    <= 1'b1;
            a_out   <= 1'b0;
            b_out   <= 1'b0;
          end else begin
            state <= DRIVE;
            idx   <= idx_nxt;
            a_out <= idx_nxt[1];
            b_out <= idx_nxt[0];
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_tt_scanner.sv
// Bench for gate_tt_scanner: a behavioural gate closes the loop, a queue holds
// the expected {tt, match} of every scan and is popped on done.
module tb_gate_tt_scanner;
  import gate_tt_pkg::*;

  localparam int G_OR  = 0;
  localparam int G_AND = 1;
  localparam int G_XOR = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start0, start1;
  logic [3:0] expected0, expected1;
  logic       a0, b0, o0, busy0, done0, match0;
  logic       a1, b1, o1, busy1, done1, match1;
  logic [3:0] tt0, tt1;
  int         mode0, mode1;
  logic       glitch1;

  int         checks   = 0;
  int         failures = 0;
  logic [4:0] sb[$];

  function automatic logic gatef(input int m, input logic a, input logic b);
    case (m)
      G_OR:    return a | b;
      G_AND:   return a & b;
      default: return a ^ b;
    endcase
  endfunction

  assign o0 = gatef(mode0, a0, b0);
  assign o1 = gatef(mode1, a1, b1) ^ glitch1;

  gate_tt_scanner #(.SETTLE_CYCLES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .expected(expected0),
    .a_out(a0), .b_out(b0), .o_in(o0), .busy(busy0), .done(done0),
    .tt(tt0), .match(match0)
  );

  gate_tt_scanner #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .expected(expected1),
    .a_out(a1), .b_out(b1), .o_in(o1), .busy(busy1), .done(done1),
    .tt(tt1), .match(match1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called from a negedge while dut0 is IDLE; returns right after the accepting edge.
  task automatic accept0(input logic [3:0] e, input logic [3:0] exp_tt, input bit push);
    expected0 = e;
    start0    = 1'b1;
    @(posedge clk);
    if (push) sb.push_back({exp_tt, exp_tt == e});
  endtask

  // k counts negedges after the accepting edge; done must first appear at k=13.
  task automatic finish0(input bit hold, input bit chk_ab, input bit chg_exp);
    int lat;
    logic [4:0] e;
    lat = 0;
    e   = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!hold) start0 = 1'b0;
      if (chg_exp && k == 5) expected0 = 4'b0000;
      if (k == 1) begin
        chk("tt_clear_on_accept", 32'(tt0), 32'd0);
        chk("busy_on_accept", 32'(busy0), 32'd1);
      end
      if (chk_ab && k <= 12) chk("ab_seq", 32'({a0, b0}), 32'((k - 1) / 3));
      if (done0) begin
        lat = k;
        break;
      end
    end
    chk("latency", 32'(lat), 32'd13);
    chk("sb_size", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) e = sb.pop_front();
    chk("tt", 32'(tt0), 32'(e[4:1]));
    chk("match", 32'(match0), 32'(e[0]));
    chk("busy_in_done", 32'(busy0), 32'd1);
    chk("ab_in_done", 32'({a0, b0}), 32'd0);
    @(negedge clk);
    chk("done_single", 32'(done0), 32'd0);
    chk("busy_fall", 32'(busy0), 32'd0);
    chk("tt_hold", 32'(tt0), 32'(e[4:1]));
    chk("match_hold", 32'(match0), 32'(e[0]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int nd;
    int lat;
    logic [4:0] e;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    expected0 = '0; expected1 = '0;
    mode0 = G_OR; mode1 = G_XOR; glitch1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_tt", 32'(tt0), 32'd0);
    chk("rst_match", 32'(match0), 32'd0);
    chk("rst_ab", 32'({a0, b0}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: or-gate, matching table
    mode0 = G_OR;
    accept0(OR_TT, OR_TT, 1'b1);
    finish0(1'b0, 1'b1, 1'b0);

    // 2: and-gate against or table
    mode0 = G_AND;
    accept0(OR_TT, AND_TT, 1'b1);
    finish0(1'b0, 1'b1, 1'b0);

    // 3: start held through a scan, re-accepted only from IDLE
    mode0 = G_XOR;
    accept0(XOR_TT, XOR_TT, 1'b1);
    finish0(1'b1, 1'b0, 1'b0);
    mode0 = G_AND;
    accept0(AND_TT, AND_TT, 1'b1);
    finish0(1'b0, 1'b0, 1'b0);

    // 4: reset while idx=2 in DRIVE
    mode0 = G_OR;
    accept0(OR_TT, OR_TT, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    chk("pre_rst_ab", 32'({a0, b0}), 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_tt", 32'(tt0), 32'd0);
    chk("midrst_match", 32'(match0), 32'd0);
    chk("midrst_ab", 32'({a0, b0}), 32'd0);
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done0) nd++;
    end
    chk("midrst_no_done", 32'(nd), 32'd0);
    accept0(OR_TT, OR_TT, 1'b1);
    finish0(1'b0, 1'b1, 1'b0);

    // 6: expected changes after acceptance
    mode0 = G_XOR;
    accept0(XOR_TT, XOR_TT, 1'b1);
    finish0(1'b0, 1'b1, 1'b1);

    // 5: SETTLE_CYCLES=1, o_in inverted during DRIVE only
    mode1 = G_XOR;
    expected1 = XOR_TT;
    start1 = 1'b1;
    @(posedge clk);
    sb.push_back({XOR_TT, 1'b1});
    lat = 0;
    for (int j = 0; j < 30; j++) begin
      #1 glitch1 = (j % 2 == 0) && (j < 8);
      @(negedge clk);
      start1 = 1'b0;
      if (done1) begin
        lat = j + 1;
        break;
      end
      @(posedge clk);
    end
    glitch1 = 1'b0;
    chk("s1_latency", 32'(lat), 32'd9);
    chk("s1_sb_size", 32'(sb.size()), 32'd1);
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    chk("s1_tt", 32'(tt1), 32'(e[4:1]));
    chk("s1_match", 32'(match1), 32'(e[0]));
    @(negedge clk);
    chk("s1_busy_fall", 32'(busy1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
